dm_arbiter: RTL and testbench

Two-port arbiter and sequencer for the 32-word data memory `dm`. Two requesters (port 0: CPU load/store stage, port 1: debug/DMA loader) share the single `dm` access path through a req/ack handshake. The block serialises accesses round-robin and drives `dm`'s write-data, address, `Memwrite` and `Memtoreg` inputs from registers. It returns read data to the granted requester.

---
 rtl/dm_arbiter.sv | 159 +++++++++++++++
 tb/tb_dm_arbiter.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/dm_arbiter.sv
// Two-port round-robin arbiter/sequencer for the 32-word data memory.
// IDLE -> ACCESS -> RESP, one access per three cycles; all outputs registered.
module dm_arbiter #(
  parameter int AW = 5,
  parameter int DW = 32
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          r0_req,
  input  logic          r0_we,
  input  logic [AW-1:0] r0_addr,
  input  logic [DW-1:0] r0_wdata,
  output logic          r0_ack,
  output logic [DW-1:0] r0_rdata,
  input  logic          r1_req,
  input  logic          r1_we,
  input  logic [AW-1:0] r1_addr,
  input  logic [DW-1:0] r1_wdata,
  output logic          r1_ack,
  output logic [DW-1:0] r1_rdata,
  output logic [DW-1:0] dm_D,
  output logic [AW-1:0] dm_A,
  output logic          dm_Memwrite,
  output logic          dm_Memtoreg,
  input  logic [DW-1:0] dm_out,
  output logic          busy,
  output logic          gnt
);

  localparam int NP = 2;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } req_t;

  req_t    [NP-1:0] req_v;
  logic    [NP-1:0] req_vld;
  logic    [NP-1:0] ack_set, rd_cap;
  logic    [NP-1:0] ack_v;
  logic    [NP-1:0][DW-1:0] rdata_v;

  state_t        state_q, state_d;
  logic          prio_q, prio_d;
  logic          gnt_q, gnt_d;
  logic          busy_q, busy_d;
  logic          we_q, we_d;
  logic [AW-1:0] dm_a_q, dm_a_d;
  logic [DW-1:0] dm_d_q, dm_d_d;
  logic          mw_q, mw_d;
  logic          mr_q, mr_d;
  logic          win;
  req_t          sel;

  assign req_v[0] = {r0_we, r0_addr, r0_wdata};
  assign req_v[1] = {r1_we, r1_addr, r1_wdata};
  assign req_vld  = {r1_req, r0_req};

  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    gnt_d   = gnt_q;
    we_d    = we_q;
    dm_a_d  = dm_a_q;
    dm_d_d  = dm_d_q;
    mw_d    = 1'b0;
    mr_d    = 1'b0;
    ack_set = '0;
    rd_cap  = '0;
    // Contention goes to prio; a lone request wins outright.
    win     = (&req_vld) ? prio_q : req_vld[1];
    sel     = req_v[win];
    unique case (state_q)
      IDLE: begin
        if (|req_vld) begin
          state_d = ACCESS;
          gnt_d   = win;
          we_d    = sel.we;
          dm_a_d  = sel.addr;
          if (sel.we) dm_d_d = sel.wdata;
          mw_d    = sel.we;
          mr_d    = ~sel.we;
        end
      end
      ACCESS: begin
        state_d         = RESP;
        ack_set[gnt_q]  = 1'b1;
        rd_cap[gnt_q]   = ~we_q;
        prio_d          = ~gnt_q;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      gnt_q   <= 1'b0;
      busy_q  <= 1'b0;
      we_q    <= 1'b0;
      dm_a_q  <= '0;
      dm_d_q  <= '0;
      mw_q    <= 1'b0;
      mr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
      we_q    <= we_d;
      dm_a_q  <= dm_a_d;
      dm_d_q  <= dm_d_d;
      mw_q    <= mw_d;
      mr_q    <= mr_d;
    end
  end

  // Per-port ack pulse and read-data hold register.
  for (genvar p = 0; p < NP; p++) begin : g_port
    logic          ack_q, ack_d;
    logic [DW-1:0] rdata_q, rdata_d;

    always_comb begin
      ack_d   = ack_set[p];
      rdata_d = rd_cap[p] ? dm_out : rdata_q;
    end

    always_ff @(posedge Clk) begin
      if (Reset) begin
        ack_q   <= 1'b0;
        rdata_q <= '0;
      end else begin
        ack_q   <= ack_d;
        rdata_q <= rdata_d;
      end
    end

    assign ack_v[p]   = ack_q;
    assign rdata_v[p] = rdata_q;
  end

  assign r0_ack      = ack_v[0];
  assign r1_ack      = ack_v[1];
  assign r0_rdata    = rdata_v[0];
  assign r1_rdata    = rdata_v[1];
  assign dm_D        = dm_d_q;
  assign dm_A        = dm_a_q;
  assign dm_Memwrite = mw_q;
  assign dm_Memtoreg = mr_q;
  assign busy        = busy_q;
  assign gnt         = gnt_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: per-cycle vector table against a 32-word memory model,
// then hand sequences for held-request spacing and a request arriving mid-access.
module tb_dm_arbiter;

  logic        Clk, Reset;
  logic        r0_req, r0_we, r1_req, r1_we;
  logic [4:0]  r0_addr, r1_addr, dm_A;
  logic [31:0] r0_wdata, r1_wdata, r0_rdata, r1_rdata, dm_D, dm_out;
  logic        r0_ack, r1_ack, dm_Memwrite, dm_Memtoreg, busy, gnt;

  logic [31:0] mem [32];
  int checks = 0, errors = 0;

  dm_arbiter #(.AW(5), .DW(32)) dut (
    .Clk(Clk), .Reset(Reset),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_ack(r0_ack), .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_ack(r1_ack), .r1_rdata(r1_rdata),
    .dm_D(dm_D), .dm_A(dm_A), .dm_Memwrite(dm_Memwrite), .dm_Memtoreg(dm_Memtoreg),
    .dm_out(dm_out), .busy(busy), .gnt(gnt)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Memory model: combinational read, write at the closing edge, cleared by Reset.
  assign dm_out = mem[dm_A];
  always @(posedge Clk) begin
    if (Reset) begin
      for (int k = 0; k < 32; k++) mem[k] <= '0;
    end else if (dm_Memwrite) begin
      mem[dm_A] <= dm_D;
    end
  end

  typedef struct {
    logic rst, q0, w0; logic [4:0] a0; logic [31:0] d0;
    logic q1, w1;      logic [4:0] a1; logic [31:0] d1;
    logic k0, k1; logic [31:0] rd0, rd1; logic [4:0] ea; logic [31:0] ed;
    logic mw, mr, bz, g;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic rst, logic q0, logic w0, logic [4:0] a0, logic [31:0] d0,
                              logic q1, logic w1, logic [4:0] a1, logic [31:0] d1,
                              logic k0, logic k1, logic [31:0] rd0, logic [31:0] rd1,
                              logic [4:0] ea, logic [31:0] ed,
                              logic mw, logic mr, logic bz, logic g);
    vec_t v;
    v.rst = rst; v.q0 = q0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
    v.q1 = q1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
    v.k0 = k0; v.k1 = k1; v.rd0 = rd0; v.rd1 = rd1; v.ea = ea; v.ed = ed;
    v.mw = mw; v.mr = mr; v.bz = bz; v.g = g;
    return v;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    r0_req = 0; r0_we = 0; r0_addr = 0; r0_wdata = 0;
    r1_req = 0; r1_we = 0; r1_addr = 0; r1_wdata = 0;
  endtask

  localparam logic [31:0] A = 32'hAAAAAAAA, F = 32'h55555555;
  localparam logic [31:0] B = 32'hDEADBEEF, C = 32'h12345678, G = 32'h0F0F0F0F;

  initial begin
    int ack_cyc[3];
    int n, c0, c1;
    Reset = 1'b1;
    idle_inputs();

    //            rst q0 w0 a0 d0  q1 w1 a1 d1 | k0 k1 rd0 rd1 ea ed mw mr bz g
    // Port 0 write 3, read back, then write 4 (rdata must hold).
    tbl.push_back(mk(1, 0,0,0,0, 0,0,0,0, 0,0,0,0, 0,0, 0,0,0,0));
    tbl.push_back(mk(0, 1,1,3,A, 0,0,0,0, 0,0,0,0, 3,A, 1,0,1,0));
    tbl.push_back(mk(0, 1,1,3,A, 0,0,0,0, 1,0,0,0, 3,A, 0,0,1,0));
    tbl.push_back(mk(0, 1,0,3,0, 0,0,0,0, 0,0,0,0, 3,A, 0,0,0,0));
    tbl.push_back(mk(0, 1,0,3,0, 0,0,0,0, 0,0,0,0, 3,A, 0,1,1,0));
    tbl.push_back(mk(0, 1,0,3,0, 0,0,0,0, 1,0,A,0, 3,A, 0,0,1,0));
    tbl.push_back(mk(0, 1,1,4,C, 0,0,0,0, 0,0,A,0, 3,A, 0,0,0,0));
    tbl.push_back(mk(0, 1,1,4,C, 0,0,0,0, 0,0,A,0, 4,C, 1,0,1,0));
    tbl.push_back(mk(0, 1,1,4,C, 0,0,0,0, 1,0,A,0, 4,C, 0,0,1,0));
    tbl.push_back(mk(0, 0,0,0,0, 0,0,0,0, 0,0,A,0, 4,C, 0,0,0,0));
    // Simultaneous arrival from reset: port 0 writes 2, port 1 reads it back.
    tbl.push_back(mk(1, 0,0,0,0, 0,0,0,0, 0,0,0,0, 0,0, 0,0,0,0));
    tbl.push_back(mk(0, 1,1,2,F, 1,0,2,0, 0,0,0,0, 2,F, 1,0,1,0));
    tbl.push_back(mk(0, 1,1,2,F, 1,0,2,0, 1,0,0,0, 2,F, 0,0,1,0));
    tbl.push_back(mk(0, 0,0,0,0, 1,0,2,0, 0,0,0,0, 2,F, 0,0,0,0));
    tbl.push_back(mk(0, 0,0,0,0, 1,0,2,0, 0,0,0,0, 2,F, 0,1,1,1));
    tbl.push_back(mk(0, 0,0,0,0, 1,0,2,0, 0,1,0,F, 2,F, 0,0,1,1));
    tbl.push_back(mk(0, 0,0,0,0, 0,0,0,0, 0,0,0,F, 2,F, 0,0,0,1));
    // Sustained contention, 12 cycles of back-to-back reads.
    tbl.push_back(mk(0, 1,0,2,0, 1,0,0,0, 0,0,0,F, 2,F, 0,1,1,0));
    tbl.push_back(mk(0, 1,0,2,0, 1,0,0,0, 1,0,F,F, 2,F, 0,0,1,0));
    tbl.push_back(mk(0, 1,0,2,0, 1,0,0,0, 0,0,F,F, 2,F, 0,0,0,0));
    tbl.push_back(mk(0, 1,0,2,0, 1,0,0,0, 0,0,F,F, 0,F, 0,1,1,1));
    tbl.push_back(mk(0, 1,0,2,0, 1,0,0,0, 0,1,F,0, 0,F, 0,0,1,1));
    tbl.push_back(mk(0, 1,0,2,0, 1,0,0,0, 0,0,F,0, 0,F, 0,0,0,1));
    tbl.push_back(mk(0, 1,0,2,0, 1,0,0,0, 0,0,F,0, 2,F, 0,1,1,0));
    tbl.push_back(mk(0, 1,0,2,0, 1,0,0,0, 1,0,F,0, 2,F, 0,0,1,0));
    tbl.push_back(mk(0, 1,0,2,0, 1,0,0,0, 0,0,F,0, 2,F, 0,0,0,0));
    tbl.push_back(mk(0, 1,0,2,0, 1,0,0,0, 0,0,F,0, 0,F, 0,1,1,1));
    tbl.push_back(mk(0, 1,0,2,0, 1,0,0,0, 0,1,F,0, 0,F, 0,0,1,1));
    tbl.push_back(mk(0, 1,0,2,0, 1,0,0,0, 0,0,F,0, 0,F, 0,0,0,1));
    tbl.push_back(mk(0, 0,0,0,0, 0,0,0,0, 0,0,F,0, 0,F, 0,0,0,1));
    // Reset during a port 1 read ACCESS; port 0 must win first afterwards.
    tbl.push_back(mk(0, 0,0,0,0, 1,0,2,0, 0,0,F,0, 2,F, 0,1,1,1));
    tbl.push_back(mk(1, 0,0,0,0, 1,0,2,0, 0,0,0,0, 0,0, 0,0,0,0));
    tbl.push_back(mk(0, 1,1,7,B, 1,0,7,0, 0,0,0,0, 7,B, 1,0,1,0));
    tbl.push_back(mk(0, 1,1,7,B, 1,0,7,0, 1,0,0,0, 7,B, 0,0,1,0));
    tbl.push_back(mk(0, 0,0,0,0, 1,0,7,0, 0,0,0,0, 7,B, 0,0,0,0));
    tbl.push_back(mk(0, 0,0,0,0, 1,0,7,0, 0,0,0,0, 7,B, 0,1,1,1));
    tbl.push_back(mk(0, 0,0,0,0, 1,0,7,0, 0,1,0,B, 7,B, 0,0,1,1));
    tbl.push_back(mk(0, 0,0,0,0, 0,0,0,0, 0,0,0,B, 7,B, 0,0,0,1));

    foreach (tbl[i]) begin
      @(negedge Clk);
      Reset = tbl[i].rst;
      r0_req = tbl[i].q0; r0_we = tbl[i].w0; r0_addr = tbl[i].a0; r0_wdata = tbl[i].d0;
      r1_req = tbl[i].q1; r1_we = tbl[i].w1; r1_addr = tbl[i].a1; r1_wdata = tbl[i].d1;
      @(posedge Clk); #1;
      chk($sformatf("vec%0d {k0,k1,rd0,rd1,A,D,mw,mr,busy,gnt}", i),
          128'({r0_ack, r1_ack, r0_rdata, r1_rdata, dm_A, dm_D, dm_Memwrite, dm_Memtoreg, busy, gnt}),
          128'({tbl[i].k0, tbl[i].k1, tbl[i].rd0, tbl[i].rd1, tbl[i].ea, tbl[i].ed,
                tbl[i].mw, tbl[i].mr, tbl[i].bz, tbl[i].g}));
    end

    // A single port held requesting is served every 3 cycles.
    @(negedge Clk);
    idle_inputs();
    r0_req = 1; r0_we = 0; r0_addr = 7;
    n = 0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge Clk); #1;
      if (r0_ack) begin
        ack_cyc[n] = c;
        n++;
        if (n == 3) break;
      end
    end
    chk("held_acks_seen", 128'(n), 128'(3));
    if (n == 3) begin
      chk("held_ack0_cycle", 128'(ack_cyc[0]), 128'(2));
      chk("held_ack_gap01", 128'(ack_cyc[1] - ack_cyc[0]), 128'(3));
      chk("held_ack_gap12", 128'(ack_cyc[2] - ack_cyc[1]), 128'(3));
    end
    chk("held_rdata", 128'(r0_rdata), 128'(B));
    @(negedge Clk);
    r0_req = 0;
    @(posedge Clk); #1;
    chk("held_idle_busy", 128'(busy), 128'(0));

    // Port 1 arrives during port 0's ACCESS: held, not lost, served after.
    @(negedge Clk);
    r0_req = 1; r0_we = 1; r0_addr = 9; r0_wdata = G;
    @(posedge Clk); #1;
    chk("late_access_mw", 128'({dm_Memwrite, dm_A, gnt}), 128'({1'b1, 5'd9, 1'b0}));
    @(negedge Clk);
    r1_req = 1; r1_we = 0; r1_addr = 9;
    c0 = 0; c1 = 0;
    for (int c = 1; c <= 10; c++) begin
      @(posedge Clk); #1;
      if (r0_ack) begin c0 = c; r0_req = 0; end
      if (r1_ack) begin c1 = c; break; end
    end
    chk("late_r0_ack_cycle", 128'(c0), 128'(1));
    chk("late_r1_ack_cycle", 128'(c1), 128'(4));
    chk("late_r1_rdata", 128'(r1_rdata), 128'(G));
    chk("late_r0_rdata_hold", 128'(r0_rdata), 128'(B));
    @(negedge Clk);
    idle_inputs();
    @(posedge Clk); #1;
    chk("final_idle", 128'({busy, r0_ack, r1_ack, dm_Memwrite, dm_Memtoreg}), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
